// File: rtl/exec_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline control and the multiply/divide unit.
interface exec_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            kill_i;
    logic            ready_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i, kill_i,
        input  ready_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, kill_i,
        output ready_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, signed fix-up.
// Optional single-entry result cache enabled by defining MD_RESULT_CACHE_EN.
module exec_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    exec_muldiv_unit_if.slave bus
);
    localparam int K  = XLEN / MUL_STEP;
    localparam int PW = XLEN + MUL_STEP;
    localparam int CW = $clog2(XLEN);

    // IDLE wait/accept | MUL shift-add | DIV restoring | FIX sign fix-up | DONE result pulse
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb, r_result;
    logic              r_sel_hi, r_is_div, r_neg_s, r_neg_r;

    logic              w_accept, w_is_div, w_sgn_a, w_sgn_b, w_sel_hi;
    logic              w_neg_a, w_neg_b, w_b_zero, w_ovf, w_hit;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_hit_res, w_quo, w_rem, w_fix_res;
    logic [PW-1:0]     w_pp, w_msum;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_prod, w_fix;
    logic              w_ready, w_busy, w_done;

    assign w_accept = (r_state == S_IDLE) & bus.start_i & ~bus.kill_i;
    assign w_is_div = bus.op_i[2];
    assign w_sgn_a  = (bus.op_i == 3'd1) | (bus.op_i == 3'd2) | (bus.op_i == 3'd4) | (bus.op_i == 3'd6);
    assign w_sgn_b  = (bus.op_i == 3'd1) | (bus.op_i == 3'd4) | (bus.op_i == 3'd6);
    assign w_sel_hi = bus.op_i[2] ? bus.op_i[1] : (bus.op_i != 3'd0);
    assign w_neg_a  = w_sgn_a & bus.a_i[XLEN-1];
    assign w_neg_b  = w_sgn_b & bus.b_i[XLEN-1];
    assign w_mag_a  = w_neg_a ? -bus.a_i : bus.a_i;
    assign w_mag_b  = w_neg_b ? -bus.b_i : bus.b_i;
    assign w_b_zero = (bus.b_i == '0);
    assign w_ovf    = w_sgn_b & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b_i);

    // Low accumulator half holds the multiplier (mul) or dividend/quotient (div).
    assign w_pp      = PW'(r_opb) * PW'(r_acc[MUL_STEP-1:0]);
    assign w_msum    = PW'(r_acc[2*XLEN-1:XLEN]) + w_pp;
    assign w_mul_nxt = {w_msum, r_acc[XLEN-1:MUL_STEP]};

    assign w_diff    = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_opb};
    assign w_div_nxt = w_diff[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_prod    = r_neg_s ? -r_acc : r_acc;
    assign w_quo     = r_neg_s ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem     = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix     = r_is_div ? {w_rem, w_quo} : w_prod;
    assign w_fix_res = r_sel_hi ? w_fix[2*XLEN-1:XLEN] : w_fix[XLEN-1:0];

`ifdef MD_RESULT_CACHE_EN
    logic              r_c_vld, r_c_div;
    logic [1:0]        r_c_cls, r_cls;
    logic [XLEN-1:0]   r_c_a, r_c_b, r_op_a, r_op_b;
    logic [2*XLEN-1:0] r_c_data;

    assign w_hit = r_c_vld & (r_c_div == w_is_div) & (r_c_cls == {w_sgn_a, w_sgn_b})
                 & (r_c_a == bus.a_i) & (r_c_b == bus.b_i);
    assign w_hit_res = w_sel_hi ? r_c_data[2*XLEN-1:XLEN] : r_c_data[XLEN-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_c_vld  <= 1'b0;
            r_c_div  <= 1'b0;
            r_c_cls  <= '0;
            r_c_a    <= '0;
            r_c_b    <= '0;
            r_c_data <= '0;
            r_cls    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= bus.a_i;
                r_op_b <= bus.b_i;
                r_cls  <= {w_sgn_a, w_sgn_b};
            end
            if ((r_state == S_FIX) && !bus.kill_i) begin
                r_c_vld  <= 1'b1;
                r_c_div  <= r_is_div;
                r_c_cls  <= r_cls;
                r_c_a    <= r_op_a;
                r_c_b    <= r_op_b;
                r_c_data <= w_fix;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_busy  = w_accept;
                if (w_accept) begin
                    if (w_hit)                              w_next = S_DONE;
                    else if (w_is_div && (w_b_zero || w_ovf)) w_next = S_FIX;
                    else if (w_is_div)                      w_next = S_DIV;
                    else                                    w_next = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                w_busy = 1'b1;
                if (bus.kill_i)        w_next = S_IDLE;
                else if (r_cnt == '0)  w_next = S_FIX;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = bus.kill_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_sel_hi <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_s  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_sel_hi <= w_sel_hi;
                    r_is_div <= w_is_div;
                    r_opb    <= w_mag_b;
                    r_cnt    <= w_is_div ? CW'(XLEN-1) : CW'(K-1);
                    if (w_hit) r_result <= w_hit_res;
                    // Special cases preload the final {remainder, quotient} pair.
                    if (w_is_div && w_b_zero) begin
                        r_acc   <= {bus.a_i, {XLEN{1'b1}}};
                        r_neg_s <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_is_div && w_ovf) begin
                        r_acc   <= {{XLEN{1'b0}}, bus.a_i};
                        r_neg_s <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                        r_neg_s <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: if (!bus.kill_i) r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.result_o = r_result;
endmodule
